// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU class codes and datapath mux selects.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXEC_R,
    EXEC_I,
    ALUWB,
    BRANCH,
    JAL,
    JALR,
    JALR_PC,
    LUI
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Must match the ALU controller's decoding of ALUOp.
  localparam logic [1:0] LS_W = 2'd0;
  localparam logic [1:0] B_T  = 2'd1;
  localparam logic [1:0] RI_T = 2'd2;
  localparam logic [1:0] U_T  = 2'd3;

  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/branch_cond.sv
// Branch resolution from ALU flags; purely combinational so it can sit in
// either the multicycle controller or a pipelined execute stage.
module branch_cond
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (func3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multicycle RV32I core: sequences each instruction
// and drives all datapath enables, mux selects and the ALUOp class.
module multicycle_main_controller
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       lt,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUOp
);

  state_t state_q, state_d;
  logic   taken;

  branch_cond u_branch_cond (
    .func3 (func3),
    .zero  (zero),
    .lt    (lt),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXEC_R;
          OP_ITYPE:          state_d = EXEC_I;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          default:           state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
      EXEC_R:   state_d = ALUWB;
      EXEC_I:   state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JAL:      state_d = ALUWB;
      JALR:     state_d = JALR_PC;
      JALR_PC:  state_d = ALUWB;
      LUI:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ImmSrc    = IMM_I;
    ALUOp     = LS_W;
    case (state_q)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      // The strobe stays up for the whole wait; memory commits on mem_ready.
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = RI_T;
      end
      EXEC_I: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = RI_T;
      end
      ALUWB:    RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = B_T;
        PCWrite = taken;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        ImmSrc  = IMM_J;
        PCWrite = 1'b1;
      end
      JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      JALR_PC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      LUI: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
        ALUOp   = U_T;
      end
      default: ;
    endcase
    // Reset aborts whatever state we were in: no writes, FETCH mux settings.
    if (rst) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALURESULT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
      ImmSrc    = IMM_I;
      ALUOp     = LS_W;
    end
  end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed-vector bench for the multicycle main controller with a queued
// expectation scoreboard and an independent negedge monitor.
module tb_multicycle_main_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       zero, lt, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  localparam logic [6:0] O_LW   = 7'b0000011;
  localparam logic [6:0] O_SW   = 7'b0100011;
  localparam logic [6:0] O_R    = 7'b0110011;
  localparam logic [6:0] O_I    = 7'b0010011;
  localparam logic [6:0] O_BR   = 7'b1100011;
  localparam logic [6:0] O_JAL  = 7'b1101111;
  localparam logic [6:0] O_JALR = 7'b1100111;
  localparam logic [6:0] O_LUI  = 7'b0110111;
  localparam logic [6:0] O_BAD  = 7'h7F;

  multicycle_main_controller dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .func3     (func3),
    .zero      (zero),
    .lt        (lt),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .ALUOp     (ALUOp)
  );

  always #5 clk = ~clk;

  // Packed {mask[15:0], value[15:0]}; a negative argument means "don't care".
  // Bit order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc[2]
  //            ALUSrcA[2] ALUSrcB[2] ImmSrc[3] ALUOp[2]
  function automatic logic [31:0] mk(int pcw, int adr, int mw, int irw, int rw,
                                     int rs, int sa, int sb, int imm, int op);
    logic [15:0] v, m;
    v = '0; m = '0;
    if (pcw >= 0) begin v[15]    = pcw[0];   m[15]    = 1'b1;   end
    if (adr >= 0) begin v[14]    = adr[0];   m[14]    = 1'b1;   end
    if (mw  >= 0) begin v[13]    = mw[0];    m[13]    = 1'b1;   end
    if (irw >= 0) begin v[12]    = irw[0];   m[12]    = 1'b1;   end
    if (rw  >= 0) begin v[11]    = rw[0];    m[11]    = 1'b1;   end
    if (rs  >= 0) begin v[10:9]  = rs[1:0];  m[10:9]  = 2'b11;  end
    if (sa  >= 0) begin v[8:7]   = sa[1:0];  m[8:7]   = 2'b11;  end
    if (sb  >= 0) begin v[6:5]   = sb[1:0];  m[6:5]   = 2'b11;  end
    if (imm >= 0) begin v[4:2]   = imm[2:0]; m[4:2]   = 3'b111; end
    if (op  >= 0) begin v[1:0]   = op[1:0];  m[1:0]   = 2'b11;  end
    return {m, v};
  endfunction

  // Hand-derived per-state expectations.
  function automatic logic [31:0] e_fetch(int mr); return mk(mr, 0, 0, mr, 0, 2, 0, 2, -1, 0); endfunction
  function automatic logic [31:0] e_branch(int t); return mk(t, -1, 0, 0, 0, 0, 2, 0, -1, 1); endfunction

  logic [31:0] e_rst, e_dec, e_madr_lw, e_madr_sw, e_mrd, e_mwb, e_mwr;
  logic [31:0] e_exr, e_exi, e_aluwb, e_jal, e_jalr, e_jalrpc, e_lui;

  task automatic step(input string nm, input logic [6:0] op, input logic [2:0] f3,
                      input logic z, input logic l, input logic mr, input logic r,
                      input logic [31:0] e);
    opcode = op; func3 = f3; zero = z; lt = l; mem_ready = mr; rst = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [15:0] act;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUOp};
      tests++;
      if ((act & e[31:16]) !== (e[15:0] & e[31:16])) begin
        fails++;
        $display("FAIL %s: got %04h required %04h (care mask %04h)",
                 nm, act, e[15:0], e[31:16]);
      end
    end
  end

  initial begin
    e_rst     = mk(0, 0, 0, 0, 0, 2, 0, 2, -1, 0);
    e_dec     = mk(0, -1, 0, 0, 0, -1, 1, 1, 2, 0);
    e_madr_lw = mk(0, -1, 0, 0, 0, -1, 2, 1, 0, 0);
    e_madr_sw = mk(0, -1, 0, 0, 0, -1, 2, 1, 1, 0);
    e_mrd     = mk(0, 1, 0, 0, 0, 0, -1, -1, -1, -1);
    e_mwb     = mk(0, -1, 0, 0, 1, 1, -1, -1, -1, -1);
    e_mwr     = mk(0, 1, 1, 0, 0, 0, -1, -1, -1, -1);
    e_exr     = mk(0, -1, 0, 0, 0, -1, 2, 0, -1, 2);
    e_exi     = mk(0, -1, 0, 0, 0, -1, 2, 1, 0, 2);
    e_aluwb   = mk(0, -1, 0, 0, 1, 0, -1, -1, -1, -1);
    e_jal     = mk(1, -1, 0, 0, 0, 0, 1, 2, -1, 0);
    e_jalr    = mk(0, -1, 0, 0, 0, -1, 2, 1, 0, 0);
    e_jalrpc  = mk(1, -1, 0, 0, 0, 0, 1, 2, -1, 0);
    e_lui     = mk(0, -1, 0, 0, 0, -1, -1, 1, 4, 3);

    rst = 1'b1; opcode = O_R; func3 = 3'b000; zero = 1'b0; lt = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    step("reset0", O_R, 3'b000, 0, 0, 1, 1, e_rst);
    step("reset1", O_R, 3'b000, 0, 0, 1, 1, e_rst);

    // add
    step("add_fetch",  O_R, 3'b000, 0, 0, 1, 0, e_fetch(1));
    step("add_decode", O_R, 3'b000, 0, 0, 1, 0, e_dec);
    step("add_exec",   O_R, 3'b000, 0, 0, 1, 0, e_exr);
    step("add_wb",     O_R, 3'b000, 0, 0, 1, 0, e_aluwb);

    // addi
    step("addi_fetch",  O_I, 3'b000, 0, 0, 1, 0, e_fetch(1));
    step("addi_decode", O_I, 3'b000, 0, 0, 1, 0, e_dec);
    step("addi_exec",   O_I, 3'b000, 0, 0, 1, 0, e_exi);
    step("addi_wb",     O_I, 3'b000, 0, 0, 1, 0, e_aluwb);

    // lw with two wait cycles in MEMREAD
    step("lw_fetch",  O_LW, 3'b010, 0, 0, 1, 0, e_fetch(1));
    step("lw_decode", O_LW, 3'b010, 0, 0, 1, 0, e_dec);
    step("lw_madr",   O_LW, 3'b010, 0, 0, 1, 0, e_madr_lw);
    step("lw_rd_w0",  O_LW, 3'b010, 0, 0, 0, 0, e_mrd);
    step("lw_rd_w1",  O_LW, 3'b010, 0, 0, 0, 0, e_mrd);
    step("lw_rd_ok",  O_LW, 3'b010, 0, 0, 1, 0, e_mrd);
    step("lw_wb",     O_LW, 3'b010, 0, 0, 1, 0, e_mwb);

    // branches
    step("beq_fetch",  O_BR, 3'b000, 1, 0, 1, 0, e_fetch(1));
    step("beq_decode", O_BR, 3'b000, 1, 0, 1, 0, e_dec);
    step("beq_taken",  O_BR, 3'b000, 1, 0, 1, 0, e_branch(1));
    step("bne_fetch",  O_BR, 3'b001, 1, 0, 1, 0, e_fetch(1));
    step("bne_decode", O_BR, 3'b001, 1, 0, 1, 0, e_dec);
    step("bne_nottk",  O_BR, 3'b001, 1, 0, 1, 0, e_branch(0));
    step("bge_fetch",  O_BR, 3'b101, 0, 0, 1, 0, e_fetch(1));
    step("bge_decode", O_BR, 3'b101, 0, 0, 1, 0, e_dec);
    step("bge_taken",  O_BR, 3'b101, 0, 0, 1, 0, e_branch(1));
    step("blt_fetch",  O_BR, 3'b100, 0, 0, 1, 0, e_fetch(1));
    step("blt_decode", O_BR, 3'b100, 0, 0, 1, 0, e_dec);
    step("blt_nottk",  O_BR, 3'b100, 0, 0, 1, 0, e_branch(0));
    step("b010_fetch", O_BR, 3'b010, 1, 1, 1, 0, e_fetch(1));
    step("b010_dec",   O_BR, 3'b010, 1, 1, 1, 0, e_dec);
    step("b010_nottk", O_BR, 3'b010, 1, 1, 1, 0, e_branch(0));

    // illegal opcode
    step("bad_fetch",  O_BAD, 3'b000, 0, 0, 1, 0, e_fetch(1));
    step("bad_decode", O_BAD, 3'b000, 0, 0, 1, 0, e_dec);

    // sw with one wait cycle
    step("sw_fetch",  O_SW, 3'b010, 0, 0, 1, 0, e_fetch(1));
    step("sw_decode", O_SW, 3'b010, 0, 0, 1, 0, e_dec);
    step("sw_madr",   O_SW, 3'b010, 0, 0, 1, 0, e_madr_sw);
    step("sw_wr_w0",  O_SW, 3'b010, 0, 0, 0, 0, e_mwr);
    step("sw_wr_ok",  O_SW, 3'b010, 0, 0, 1, 0, e_mwr);

    // sw aborted by reset while waiting in MEMWRITE
    step("swr_fetch",  O_SW, 3'b010, 0, 0, 1, 0, e_fetch(1));
    step("swr_decode", O_SW, 3'b010, 0, 0, 1, 0, e_dec);
    step("swr_madr",   O_SW, 3'b010, 0, 0, 1, 0, e_madr_sw);
    step("swr_rst",    O_SW, 3'b010, 0, 0, 0, 1, e_rst);
    step("swr_after",  O_SW, 3'b010, 0, 0, 0, 0, e_fetch(0));

    // jal with one fetch wait
    step("jal_fetch_w", O_JAL, 3'b000, 0, 0, 1, 0, e_fetch(1));
    step("jal_decode",  O_JAL, 3'b000, 0, 0, 1, 0, e_dec);
    step("jal_pc",      O_JAL, 3'b000, 0, 0, 1, 0, e_jal);
    step("jal_wb",      O_JAL, 3'b000, 0, 0, 1, 0, e_aluwb);

    // lui, entered through a stalled fetch
    step("lui_fetch_w", O_LUI, 3'b000, 0, 0, 0, 0, e_fetch(0));
    step("lui_fetch",   O_LUI, 3'b000, 0, 0, 1, 0, e_fetch(1));
    step("lui_decode",  O_LUI, 3'b000, 0, 0, 1, 0, e_dec);
    step("lui_exec",    O_LUI, 3'b000, 0, 0, 1, 0, e_lui);
    step("lui_wb",      O_LUI, 3'b000, 0, 0, 1, 0, e_aluwb);

    // jalr
    step("jalr_fetch",  O_JALR, 3'b000, 0, 0, 1, 0, e_fetch(1));
    step("jalr_decode", O_JALR, 3'b000, 0, 0, 1, 0, e_dec);
    step("jalr_addr",   O_JALR, 3'b000, 0, 0, 1, 0, e_jalr);
    step("jalr_pc",     O_JALR, 3'b000, 0, 0, 1, 0, e_jalrpc);
    step("jalr_wb",     O_JALR, 3'b000, 0, 0, 1, 0, e_aluwb);
    step("final_fetch", O_R,    3'b000, 0, 0, 1, 0, e_fetch(1));

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      if (exp_q.size() > 0) begin
        tests++;
        fails++;
        $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
